seg_tagger: RTL
===============

# seg_tagger

Front end of the segmented CRC datapath. It accepts a raw segmented packet bus (SEG_NUM lanes of SEG_BYTES bytes per beat), tracks packet boundaries across beats and emits the per-segment tag set consumed by the merge tree: sop, eop, dval, packet_num and zero_num, plus zero-masked lane data. It sits between the MAC-side segmented interface and the per-segment CRC engines, so the first merge layer sees tags in exactly the format it consumes.

## Interface
- SEG_NUM, 8: lanes per beat; power of two, 2..64.
- SEG_BYTES, 8: bytes per lane; power of two; SEG_NUM*SEG_BYTES ≤ 4095.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  beat qualifier.
- in_seg_valid  in  SEG_NUM  lane carries bytes.
- in_seg_sop  in  SEG_NUM  lane holds a packet's first byte at its MSB byte.
- in_seg_eop  in  SEG_NUM  lane holds a packet's last byte.
- in_seg_empty  in  SEG_NUM*log2(SEG_BYTES)  unused trailing bytes in eop lane.
- in_data  in  SEG_NUM*SEG_BYTES*8  lane data; lane SEG_NUM-1 is earliest on the wire.
- out_sop / out_eop / out_dval  out  SEG_NUM each  per-lane tags.
- out_packet_num  out  4*SEG_NUM  packet id owning each lane.
- out_zero_num  out  12*SEG_NUM  pad bytes following the eop byte to end of beat.
- out_data  out  SEG_NUM*SEG_BYTES*8  masked data.
- out_err  out  1  one-cycle protocol-error pulse.

## Operation
- Lane order per beat: SEG_NUM-1 down to 0. State carried across beats: active (inside packet), pkt_id[3:0].
- Walking lanes in order: sop sets active, increments pkt_id (wrap 15→0), and the lane takes the new id. A lane with sop and eop together is a one-lane packet. eop clears active after the lane.
- dval = in_valid & in_seg_valid & (active before lane | sop on lane).
- zero_num on eop lane = empty + SEG_BYTES*k, where k = lane index (lanes after it in the beat). All non-eop lanes: 0.
- Masking: bytes of dval=0 lanes → 0; trailing `empty` bytes of eop lane → 0.
- Errors (out_err=1, two cycles after the offending beat):
  - sop while active: previous packet abandoned, new packet starts normally.
  - eop while not active: lane dval=0, eop/sop tags 0.
  - valid lane while not active without sop: dval=0.
- in_valid=0: all lane tags 0, data 0, state held.

## Timing
- Fixed latency 2: stage 1 registers inputs and resolves per-lane active/id via an in-beat ripple. Stage 2 computes zero_num and masking, and registers outputs.
- No backpressure: one beat accepted per cycle, matching the merge tree.
- Reset (rst_n=0 at a clk edge): all outputs 0, active=0, pkt_id=15 (first packet gets id 0). Pipeline contents are discarded. A packet straddling reset is lost, with no err pulse.
- Sustained full rate: a beat holding eop on lane j and sop on lane j-1 produces both tags in the same output beat. The ids differ by 1 mod 16.

## Structure
- seg_pkg: PKT_NUM_W=4, ZERO_NUM_W=12, and width helper functions. These are shared with the merge layers and CRC engines.
- One sub-module, seg_zero_count: combinational eop-lane→zero_num and byte-mask generator, instantiated in stage 2.
- Top level holds the two pipeline registers and the cross-beat state.

## Test plan
- Reset, then idle → all outputs 0 and out_err=0 for 10 cycles.
- SEG_NUM=8, SEG_BYTES=8: one beat with sop on lane 7, eop on lane 5, empty=3 → two cycles later dval=0b11100000, packet_num=0 on lanes 7..5, zero_num[lane5]=3+40=43, lane-5 low 3 bytes zero.
- 3-beat packet with sop on lane 7 of beat 1 and eop on lane 0 (empty=0) of beat 3 → all 24 lanes dval=1, id 0, zero_num[lane0]=0.
- Back-to-back packets: eop lane 4, sop lane 3 in one beat, 17 packets total → ids wrap 15→0, no err.
- sop while active → out_err pulse once; new id = old+1; data otherwise unaffected.
- Assert rst_n=0 mid-packet for one cycle → outputs 0 the next cycle; the next sop gets id 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared widths and helpers for the segmented CRC datapath (tagger, merge layers, CRC engines).
package seg_pkg;

  localparam int PKT_NUM_W  = 4;
  localparam int ZERO_NUM_W = 12;

  typedef logic [PKT_NUM_W-1:0]  pkt_id_t;
  typedef logic [ZERO_NUM_W-1:0] zero_num_t;

  // Width of one lane's empty field; a 1-byte lane still carries a 1-bit field.
  function automatic int empty_w(input int seg_bytes);
    return (seg_bytes > 1) ? $clog2(seg_bytes) : 1;
  endfunction

  // Width of one lane's data in bits.
  function automatic int lane_w(input int seg_bytes);
    return seg_bytes * 8;
  endfunction

endpackage

// File: rtl/seg_zero_count.sv
// Combinational eop-lane to zero_num conversion and per-byte keep mask for one beat.
module seg_zero_count
  import seg_pkg::*;
#(
  parameter int SEG_NUM   = 8,
  parameter int SEG_BYTES = 8
) (
  input  logic [SEG_NUM-1:0]                    eop_i,
  input  logic [SEG_NUM-1:0]                    dval_i,
  input  logic [SEG_NUM*empty_w(SEG_BYTES)-1:0] empty_i,
  output logic [SEG_NUM*ZERO_NUM_W-1:0]         zero_num_o,
  output logic [SEG_NUM*SEG_BYTES-1:0]          byte_keep_o
);

  localparam int EW = empty_w(SEG_BYTES);

  // zero_num counts the eop lane's own empty bytes plus every full lane after it;
  // byte b=0 is the last byte of a lane, so empty bytes are the low-order ones.
  always_comb begin
    zero_num_o  = '0;
    byte_keep_o = '0;
    for (int i = 0; i < SEG_NUM; i++) begin
      if (eop_i[i]) begin
        zero_num_o[i*ZERO_NUM_W +: ZERO_NUM_W] =
          ZERO_NUM_W'(empty_i[i*EW +: EW]) + ZERO_NUM_W'(SEG_BYTES * i);
      end
      for (int b = 0; b < SEG_BYTES; b++) begin
        byte_keep_o[i*SEG_BYTES + b] =
          dval_i[i] & ~(eop_i[i] & (b < int'(empty_i[i*EW +: EW])));
      end
    end
  end

endmodule

// File: rtl/seg_tagger.sv
// Segmented-bus front end: tracks packet boundaries across beats and emits per-lane
// sop/eop/dval/packet_num/zero_num tags plus zero-masked data, two cycles after input.
// No backpressure: one beat per cycle, every cycle.
module seg_tagger
  import seg_pkg::*;
#(
  parameter int SEG_NUM   = 8,
  parameter int SEG_BYTES = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  input  logic [SEG_NUM-1:0]                    in_seg_valid,
  input  logic [SEG_NUM-1:0]                    in_seg_sop,
  input  logic [SEG_NUM-1:0]                    in_seg_eop,
  input  logic [SEG_NUM*empty_w(SEG_BYTES)-1:0] in_seg_empty,
  input  logic [SEG_NUM*SEG_BYTES*8-1:0]        in_data,
  output logic [SEG_NUM-1:0]                    out_sop,
  output logic [SEG_NUM-1:0]                    out_eop,
  output logic [SEG_NUM-1:0]                    out_dval,
  output logic [SEG_NUM*PKT_NUM_W-1:0]          out_packet_num,
  output logic [SEG_NUM*ZERO_NUM_W-1:0]         out_zero_num,
  output logic [SEG_NUM*SEG_BYTES*8-1:0]        out_data,
  output logic                                  out_err
);

  localparam int EW = empty_w(SEG_BYTES);
  localparam int DW = SEG_NUM * lane_w(SEG_BYTES);

  // Cross-beat state
  logic    active_q, active_d;
  pkt_id_t pkt_id_q, pkt_id_d;

  // Stage-1 results of the in-beat ripple
  logic [SEG_NUM-1:0]           sop_d, eop_d, dval_d;
  logic [SEG_NUM*PKT_NUM_W-1:0] id_d;
  logic                         err_d;

  logic [SEG_NUM-1:0]           s1_sop_q, s1_eop_q, s1_dval_q;
  logic [SEG_NUM*PKT_NUM_W-1:0] s1_id_q;
  logic [SEG_NUM*EW-1:0]        s1_empty_q;
  logic [DW-1:0]                s1_data_q;
  logic                         s1_err_q;

  // Stage-2 combinational results and output registers
  logic [SEG_NUM*ZERO_NUM_W-1:0] zero_num_d;
  logic [SEG_NUM*SEG_BYTES-1:0]  byte_keep;
  logic [DW-1:0]                 data_d;

  logic [SEG_NUM-1:0]            out_sop_q, out_eop_q, out_dval_q;
  logic [SEG_NUM*PKT_NUM_W-1:0]  out_pkt_q;
  logic [SEG_NUM*ZERO_NUM_W-1:0] out_zero_q;
  logic [DW-1:0]                 out_data_q;
  logic                          out_err_q;

  // Walk lanes earliest-first (SEG_NUM-1 down to 0), carrying active/id lane to lane.
  // A lane is only considered when its seg_valid bit is set; eop is honoured only on
  // a lane that belongs to a packet, otherwise it is flagged and dropped.
  always_comb begin
    active_d = active_q;
    pkt_id_d = pkt_id_q;
    sop_d    = '0;
    eop_d    = '0;
    dval_d   = '0;
    id_d     = '0;
    err_d    = 1'b0;
    if (in_valid) begin
      for (int i = SEG_NUM - 1; i >= 0; i--) begin
        if (in_seg_valid[i] && in_seg_sop[i]) begin
          if (active_d) err_d = 1'b1;  // previous packet abandoned
          active_d  = 1'b1;
          pkt_id_d  = pkt_id_d + pkt_id_t'(1);
          sop_d[i]  = 1'b1;
          dval_d[i] = 1'b1;
        end else if (in_seg_valid[i]) begin
          if (active_d) dval_d[i] = 1'b1;
          else          err_d     = 1'b1;  // data outside any packet
        end
        if (in_seg_valid[i] && in_seg_eop[i] && dval_d[i]) begin
          eop_d[i] = 1'b1;
          active_d = 1'b0;
        end
        if (dval_d[i]) id_d[i*PKT_NUM_W +: PKT_NUM_W] = pkt_id_d;
      end
    end
  end

  // Stage 1: register ripple results and raw lane data; advance cross-beat state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      pkt_id_q   <= '1;
      s1_sop_q   <= '0;
      s1_eop_q   <= '0;
      s1_dval_q  <= '0;
      s1_id_q    <= '0;
      s1_empty_q <= '0;
      s1_data_q  <= '0;
      s1_err_q   <= 1'b0;
    end else begin
      active_q   <= active_d;
      pkt_id_q   <= pkt_id_d;
      s1_sop_q   <= sop_d;
      s1_eop_q   <= eop_d;
      s1_dval_q  <= dval_d;
      s1_id_q    <= id_d;
      s1_empty_q <= in_seg_empty;
      s1_data_q  <= in_data;
      s1_err_q   <= err_d;
    end
  end

  seg_zero_count #(
    .SEG_NUM   (SEG_NUM),
    .SEG_BYTES (SEG_BYTES)
  ) u_zero_count (
    .eop_i       (s1_eop_q),
    .dval_i      (s1_dval_q),
    .empty_i     (s1_empty_q),
    .zero_num_o  (zero_num_d),
    .byte_keep_o (byte_keep)
  );

  // Zero every byte the keep mask rejects.
  always_comb begin
    data_d = '0;
    for (int k = 0; k < SEG_NUM * SEG_BYTES; k++) begin
      data_d[k*8 +: 8] = s1_data_q[k*8 +: 8] & {8{byte_keep[k]}};
    end
  end

  // Stage 2: register the finished tag set and masked data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sop_q  <= '0;
      out_eop_q  <= '0;
      out_dval_q <= '0;
      out_pkt_q  <= '0;
      out_zero_q <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      out_sop_q  <= s1_sop_q;
      out_eop_q  <= s1_eop_q;
      out_dval_q <= s1_dval_q;
      out_pkt_q  <= s1_id_q;
      out_zero_q <= zero_num_d;
      out_data_q <= data_d;
      out_err_q  <= s1_err_q;
    end
  end

  assign out_sop        = out_sop_q;
  assign out_eop        = out_eop_q;
  assign out_dval       = out_dval_q;
  assign out_packet_num = out_pkt_q;
  assign out_zero_num   = out_zero_q;
  assign out_data       = out_data_q;
  assign out_err        = out_err_q;

endmodule
